// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: per-source result FIFOs feeding one registered CDB broadcast
// per cycle, granted round-robin over the non-empty FIFOs.
module cdb_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int DEPTH   = 2,
    parameter int TAG_W   = 6,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic [NUM_SRC-1:0]        src_valid,
    output logic [NUM_SRC-1:0]        src_ready,
    input  logic [NUM_SRC*TAG_W-1:0]  src_prd,
    input  logic [NUM_SRC*TAG_W-1:0]  src_rob,
    input  logic [NUM_SRC*DATA_W-1:0] src_value,
    input  logic [NUM_SRC-1:0]        src_regwrite,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_prd,
    output logic [TAG_W-1:0]          cdb_rob,
    output logic [DATA_W-1:0]         cdb_value,
    output logic                      cdb_regwrite,
    output logic [1:0]                cdb_src
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SRC_W = $clog2(NUM_SRC);

    logic [TAG_W-1:0]  r_prd_mem   [NUM_SRC][DEPTH];
    logic [TAG_W-1:0]  r_rob_mem   [NUM_SRC][DEPTH];
    logic [DATA_W-1:0] r_value_mem [NUM_SRC][DEPTH];
    logic              r_rw_mem    [NUM_SRC][DEPTH];

    logic [PTR_W-1:0]  r_rd_ptr [NUM_SRC];
    logic [PTR_W-1:0]  r_wr_ptr [NUM_SRC];
    logic [CNT_W-1:0]  r_count  [NUM_SRC];
    logic [SRC_W-1:0]  r_rr_ptr;

    logic              r_cdb_valid;
    logic [TAG_W-1:0]  r_cdb_prd;
    logic [TAG_W-1:0]  r_cdb_rob;
    logic [DATA_W-1:0] r_cdb_value;
    logic              r_cdb_regwrite;
    logic [1:0]        r_cdb_src;

    logic [NUM_SRC-1:0] w_nonempty;
    logic [NUM_SRC-1:0] w_enq;
    logic [NUM_SRC-1:0] w_deq;
    logic               w_grant;
    logic [SRC_W-1:0]   w_winner;
    logic [SRC_W-1:0]   w_next_rr;

    // Ready looks only at the count held at the start of the cycle, so a full FIFO
    // being drained this cycle still refuses a new result.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            src_ready[i]  = (r_count[i] < CNT_W'(DEPTH)) && !reset && !flush;
            w_nonempty[i] = (r_count[i] != '0);
            w_enq[i]      = src_valid[i] && src_ready[i];
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        int idx;
        idx      = 0;
        w_grant  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = (int'(r_rr_ptr) + k) % NUM_SRC;
            if (!w_grant && w_nonempty[idx]) begin
                w_grant  = 1'b1;
                w_winner = SRC_W'(idx);
            end
        end
        w_next_rr = SRC_W'((int'(w_winner) + 1) % NUM_SRC);
        for (int i = 0; i < NUM_SRC; i++) begin
            w_deq[i] = w_grant && (w_winner == SRC_W'(i)) && !reset && !flush;
        end
    end

    // NOTE: FIFO storage is deliberately not reset; the counts alone decide what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_enq[i]) begin
                r_prd_mem[i][r_wr_ptr[i]]   <= src_prd[i*TAG_W +: TAG_W];
                r_rob_mem[i][r_wr_ptr[i]]   <= src_rob[i*TAG_W +: TAG_W];
                r_value_mem[i][r_wr_ptr[i]] <= src_value[i*DATA_W +: DATA_W];
                r_rw_mem[i][r_wr_ptr[i]]    <= src_regwrite[i];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                r_rd_ptr[i] <= '0;
                r_wr_ptr[i] <= '0;
                r_count[i]  <= '0;
            end
            r_rr_ptr       <= '0;
            r_cdb_valid    <= 1'b0;
            r_cdb_prd      <= '0;
            r_cdb_rob      <= '0;
            r_cdb_value    <= '0;
            r_cdb_regwrite <= 1'b0;
            r_cdb_src      <= '0;
        end else if (flush) begin
            // Mispredict: drop everything queued; the round-robin position survives.
            for (int i = 0; i < NUM_SRC; i++) begin
                r_rd_ptr[i] <= '0;
                r_wr_ptr[i] <= '0;
                r_count[i]  <= '0;
            end
            r_cdb_valid <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (w_enq[i]) r_wr_ptr[i] <= r_wr_ptr[i] + PTR_W'(1);
                if (w_deq[i]) r_rd_ptr[i] <= r_rd_ptr[i] + PTR_W'(1);
                case ({w_enq[i], w_deq[i]})
                    2'b10:   r_count[i] <= r_count[i] + CNT_W'(1);
                    2'b01:   r_count[i] <= r_count[i] - CNT_W'(1);
                    default: r_count[i] <= r_count[i];
                endcase
            end
            r_cdb_valid <= w_grant;
            if (w_grant) begin
                r_cdb_prd      <= r_prd_mem[w_winner][r_rd_ptr[w_winner]];
                r_cdb_rob      <= r_rob_mem[w_winner][r_rd_ptr[w_winner]];
                r_cdb_value    <= r_value_mem[w_winner][r_rd_ptr[w_winner]];
                r_cdb_regwrite <= r_rw_mem[w_winner][r_rd_ptr[w_winner]];
                r_cdb_src      <= 2'(w_winner);
                r_rr_ptr       <= w_next_rr;
            end
        end
    end

    assign cdb_valid    = r_cdb_valid;
    assign cdb_prd      = r_cdb_prd;
    assign cdb_rob      = r_cdb_rob;
    assign cdb_value    = r_cdb_value;
    assign cdb_regwrite = r_cdb_regwrite;
    assign cdb_src      = r_cdb_src;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus random traffic, compared each cycle
// against a queue-based model of the per-source FIFOs and the round-robin grant.
module tb_cdb_arbiter;

    localparam int NS    = 4;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [5:0]  prd;
        logic [5:0]  rob;
        logic [31:0] value;
        logic        rw;
    } res_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         flush = 1'b0;
    logic [3:0]   src_valid = '0;
    logic [3:0]   src_ready;
    logic [23:0]  src_prd = '0;
    logic [23:0]  src_rob = '0;
    logic [127:0] src_value = '0;
    logic [3:0]   src_regwrite = '0;
    logic         cdb_valid;
    logic [5:0]   cdb_prd;
    logic [5:0]   cdb_rob;
    logic [31:0]  cdb_value;
    logic         cdb_regwrite;
    logic [1:0]   cdb_src;

    cdb_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .src_valid    (src_valid),
        .src_ready    (src_ready),
        .src_prd      (src_prd),
        .src_rob      (src_rob),
        .src_value    (src_value),
        .src_regwrite (src_regwrite),
        .cdb_valid    (cdb_valid),
        .cdb_prd      (cdb_prd),
        .cdb_rob      (cdb_rob),
        .cdb_value    (cdb_value),
        .cdb_regwrite (cdb_regwrite),
        .cdb_src      (cdb_src)
    );

    always #5 clk = ~clk;

    // Reference model state: one queue of accepted results per source.
    res_t       q [NS][$];
    int         rr = 0;
    logic       e_valid = 1'b0;
    logic [1:0] e_src = '0;
    res_t       e_f = '0;
    logic [3:0] last_acc = '0;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_src(input int i, input logic v, input logic [5:0] p, input logic [5:0] r,
                           input logic [31:0] val, input logic rw);
        src_valid[i]           = v;
        src_prd[i*6 +: 6]      = p;
        src_rob[i*6 +: 6]      = r;
        src_value[i*32 +: 32]  = val;
        src_regwrite[i]        = rw;
    endtask

    // One clock: check ready, advance the model across the edge, then check the CDB.
    task automatic tick();
        logic [3:0] er;
        logic [3:0] take;
        res_t       acc [NS];
        int         s;
        bit         found;
        @(negedge clk);
        for (int i = 0; i < NS; i++) begin
            er[i]   = (q[i].size() < DEPTH) && !reset && !flush;
            take[i] = src_valid[i] && er[i];
            acc[i]  = '{src_prd[i*6 +: 6], src_rob[i*6 +: 6], src_value[i*32 +: 32], src_regwrite[i]};
        end
        check("src_ready", 64'(src_ready), 64'(er));
        last_acc = take;
        if (reset) begin
            for (int i = 0; i < NS; i++) q[i].delete();
            rr = 0; e_valid = 1'b0; e_src = '0; e_f = '0;
        end else if (flush) begin
            for (int i = 0; i < NS; i++) q[i].delete();
            e_valid = 1'b0;
        end else begin
            found = 1'b0;
            for (int k = 0; k < NS; k++) begin
                s = (rr + k) % NS;
                if (!found && q[s].size() > 0) begin
                    found = 1'b1;
                    e_f   = q[s].pop_front();
                    e_src = 2'(s);
                    rr    = (s + 1) % NS;
                end
            end
            e_valid = found;
            for (int i = 0; i < NS; i++) if (take[i]) q[i].push_back(acc[i]);
        end
        @(posedge clk);
        #1;
        check("cdb_valid", 64'(cdb_valid), 64'(e_valid));
        check("cdb_fields", 64'({cdb_src, cdb_prd, cdb_rob, cdb_value, cdb_regwrite}), 64'({e_src, e_f}));
    endtask

    task automatic idle();
        src_valid = '0;
        flush     = 1'b0;
        reset     = 1'b0;
    endtask

    initial begin
        int seq [NS];

        // Reset then idle.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (10) tick();

        // Single result from source 1.
        set_src(1, 1'b1, 6'd4, 6'd2, 32'hCCCCCCCC, 1'b1);
        tick();
        idle();
        tick();
        check("single_src", 64'(cdb_src), 64'd1);
        check("single_rob", 64'(cdb_rob), 64'd2);
        tick();

        // Round-robin: two simultaneous bursts from a freshly reset arbiter.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < NS; i++)
                set_src(i, 1'b1, 6'(i + 1), 6'(10 + 10 * b + i), 32'(100 * b + i), i[0]);
            tick();
            idle();
            repeat (5) tick();
        end

        // Back-pressure: every source held valid, data advances only when accepted.
        for (int i = 0; i < NS; i++) begin
            seq[i] = 0;
            set_src(i, 1'b1, 6'(i), 6'(i * 16), 32'h1000 * i, 1'b1);
        end
        repeat (24) begin
            tick();
            for (int i = 0; i < NS; i++) begin
                if (last_acc[i]) begin
                    seq[i]++;
                    set_src(i, 1'b1, 6'(i), 6'(i * 16 + seq[i]), 32'h1000 * i + 32'(seq[i]), seq[i][0]);
                end
            end
        end
        idle();
        repeat (12) tick();

        // Source 0 streams alone: enqueue and dequeue every cycle.
        for (int n = 0; n < 8; n++) begin
            set_src(0, 1'b1, 6'(n + 3), 6'(n + 40), 32'hA0A0_0000 + 32'(n), 1'b1);
            tick();
        end
        idle();
        repeat (3) tick();

        // Flush with results queued in sources 0 and 2; the flush-cycle enqueue is dropped.
        for (int n = 0; n < 3; n++) begin
            set_src(0, 1'b1, 6'(n), 6'(50 + n), 32'(n), 1'b0);
            set_src(2, 1'b1, 6'(n), 6'(55 + n), 32'(n + 8), 1'b1);
            if (n == 2) flush = 1'b1;
            tick();
        end
        idle();
        repeat (5) tick();

        // Random traffic with occasional flush and reset.
        repeat (400) begin
            for (int i = 0; i < NS; i++)
                set_src(i, 1'($urandom_range(0, 2) != 0), 6'($urandom), 6'($urandom), $urandom, 1'($urandom));
            flush = ($urandom_range(0, 29) == 0);
            reset = ($urandom_range(0, 149) == 0);
            tick();
        end
        idle();
        repeat (10) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common-data-bus arbiter for the out-of-order core. It collects completed results from the three ALU pipes and the load/store unit, buffers each source in a small per-source FIFO, and broadcasts one result per cycle on the single CDB. The CDB feeds the reservation-station wakeup logic, the physical register file and the ROB. Sources that do not win stall through a ready/valid handshake instead of dropping results.

## Interface
Parameters:
- NUM_SRC, 4, number of result sources (0-2 = ALU0-2, 3 = LSU)
- DEPTH, 2, entries per source FIFO (power of two, ≥2)
- TAG_W, 6, width of physical-register and ROB tags
- DATA_W, 32, result width

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  synchronous clear of all queued results (branch mispredict)
- src_valid  in  NUM_SRC  per-source result valid
- src_ready  out  NUM_SRC  per-source FIFO can accept
- src_prd  in  NUM_SRC*TAG_W  destination physical reg, source i at [i*TAG_W +: TAG_W]
- src_rob  in  NUM_SRC*TAG_W  ROB number, same packing
- src_value  in  NUM_SRC*DATA_W  result value, same packing
- src_regwrite  in  NUM_SRC  result writes a register
- cdb_valid  out  1  broadcast valid
- cdb_prd  out  TAG_W  broadcast physical reg
- cdb_rob  out  TAG_W  broadcast ROB number
- cdb_value  out  DATA_W  broadcast value
- cdb_regwrite  out  1  broadcast regwrite
- cdb_src  out  2  index of winning source

## Operation
- Per-source FIFO: entry = {prd, rob, value, regwrite}. Each FIFO has a read pointer, a write pointer and a count (0..DEPTH).
- Enqueue for source i on an edge where src_valid[i] && src_ready[i].
- src_ready[i] = (count_i < DEPTH) && !reset && !flush. It is computed from the count at the start of the cycle. A full FIFO that dequeues this cycle still shows ready=0.
- Arbitration is combinational over non-empty FIFOs, round-robin. Search order is rr_ptr, rr_ptr+1, … mod NUM_SRC. The first non-empty source wins.
- On a grant: dequeue the winner's head, register it onto cdb_*, and set rr_ptr ← (winner+1) mod NUM_SRC.
- With no non-empty FIFO: cdb_valid ← 0, rr_ptr unchanged, and cdb_prd/rob/value/regwrite/src hold their previous values.
- The CDB has no back-pressure. A broadcast is consumed in the cycle it is valid.
- Simultaneous enqueue and dequeue on the same FIFO: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- FIFO order is strict per source. Results from one source leave in the order they were accepted.
- flush: all counts and pointers → 0, cdb_valid ← 0 next edge, and any enqueue in the flush cycle is discarded. rr_ptr is not reset.
- reset: all counts and pointers → 0, rr_ptr → 0, and all cdb_* outputs → 0.

## Timing
- Reset values: cdb_valid=0, cdb_prd=0, cdb_rob=0, cdb_value=0, cdb_regwrite=0, cdb_src=0. src_ready is all 0 while reset is high and all 1 in the first cycle after reset deasserts.
- Latency: a result accepted on edge E is eligible in the cycle after E. At the earliest it is on cdb_* after edge E+1, i.e. one cycle of buffering, fully registered.
- Throughput: one broadcast per cycle whenever any FIFO is non-empty.
- Fairness: with all NUM_SRC FIFOs continuously non-empty, each source is granted exactly once every NUM_SRC cycles.
- Full FIFO: src_ready[i] deasserts in the cycle that count reaches DEPTH. It reasserts the cycle after the first dequeue from that FIFO.
- Reset or flush mid-stream: queued results are lost. cdb_valid is 0 in the cycle after the reset/flush edge, with no partial broadcast.

## Test plan
- Reset then idle: hold reset 1 cycle. After it, cdb_valid=0 and all outputs 0, src_ready=4'b1111. No cdb_valid over 10 idle cycles.
- Single result: source 1 presents prd=6'd4, rob=6'd2, value=32'hCCCCCCCC, regwrite=1 for one cycle. Exactly one cycle later: cdb_valid=1, cdb_src=1, fields match. Next cycle cdb_valid=0.
- Round-robin: all four sources enqueue in the same cycle with rob=10,11,12,13. The CDB emits rob 10,11,12,13 (src 0,1,2,3) on consecutive cycles. A second simultaneous burst starts from src 0 again, because rr_ptr wrapped to 0.
- Back-pressure: source 3 holds valid with distinct rob values while sources 0-2 are always busy. src_ready[3] drops after 2 accepts. No rob value from source 3 is lost or reordered, and each source is granted every 4th cycle.
- Enqueue/dequeue same cycle: source 0 streams one result per cycle, alone. Count stays at 1, src_ready[0] stays 1, and the CDB emits every value in order with 1-cycle latency.
- Flush: queue 2 results in each of sources 0 and 2, then assert flush for one cycle. cdb_valid=0 the next cycle and stays 0, and src_ready returns to 4'b1111.
